// File: rtl/cmd_regfile_if.sv
// Command/result handshake bundle for cmd_regfile.
// The master issues commands and consumes results; the slave is the register file.
interface cmd_regfile_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [3:0]            cmd_op;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rd_ready,
      input  cmd_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rd_ready,
      output cmd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/cmd_regfile.sv
// Command-driven register file with select latches, SP stepping and an ALU flag path.
// Reads: latency 1, single result slot; a new command is taken only when the slot is free or draining.
module cmd_regfile #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    REGISTERS   = 8,
   parameter int                    INDEX_WIDTH = $clog2(REGISTERS),
   parameter int                    RV_INDEX    = 5,
   parameter int                    F_INDEX     = 6,
   parameter int                    SP_INDEX    = 7,
   parameter logic [DATA_WIDTH-1:0] SP_RESET    = 16'hFFFE,
   parameter int                    SP_STEP     = 2,
   parameter bit                    ZERO_R0     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cmd_regfile_if.slave          bus,
   input  logic                  alu_f_we,
   input  logic [DATA_WIDTH-1:0] alu_f_data,
   output logic [DATA_WIDTH-1:0] f_out,
   output logic [DATA_WIDTH-1:0] sp_out,
   output logic                  err
);

   typedef enum logic [3:0] {
      OP_NOP      = 4'h0,
      OP_READA    = 4'h1,
      OP_READB    = 4'h2,
      OP_LATCHC   = 4'h3,
      OP_LATCHSEL = 4'h4,
      OP_READSP   = 4'h5,
      OP_READF    = 4'h6,
      OP_READRV   = 4'h7,
      OP_LATCHSP  = 4'h8,
      OP_LATCHF   = 4'h9,
      OP_LATCHRV  = 4'hA,
      OP_INCSP    = 4'hB,
      OP_DECSP    = 4'hC
   } op_e;

   localparam logic [INDEX_WIDTH-1:0] RV_I      = RV_INDEX[INDEX_WIDTH-1:0];
   localparam logic [INDEX_WIDTH-1:0] F_I       = F_INDEX[INDEX_WIDTH-1:0];
   localparam logic [INDEX_WIDTH-1:0] SP_I      = SP_INDEX[INDEX_WIDTH-1:0];
   localparam logic [INDEX_WIDTH:0]   REG_CNT   = REGISTERS[INDEX_WIDTH:0];
   localparam logic [DATA_WIDTH-1:0]  SP_STEP_W = SP_STEP[DATA_WIDTH-1:0];

   if (REGISTERS < 4 || 3 * INDEX_WIDTH > DATA_WIDTH) begin : g_bad_params
      $error("cmd_regfile: REGISTERS must be >= 4 and three selects must fit in DATA_WIDTH");
   end

   logic [DATA_WIDTH-1:0]  regs_q [REGISTERS];
   logic [DATA_WIDTH-1:0]  regs_d [REGISTERS];
   logic [INDEX_WIDTH-1:0] sel_a_q, sel_b_q, sel_c_q;
   logic [INDEX_WIDTH-1:0] sel_a_d, sel_b_d, sel_c_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                   err_q, err_d;

   logic                   accept;
   op_e                    op;
   logic                   is_read, is_illegal, sel_we, wr_en;
   logic [INDEX_WIDTH-1:0] rd_sel, wr_idx;
   logic [DATA_WIDTH-1:0]  wr_val, rd_val;

   assign bus.cmd_ready = ~rd_valid_q | bus.rd_ready;
   assign accept        = bus.cmd_valid & bus.cmd_ready;
   assign op            = op_e'(bus.cmd_op);

   always_comb begin
      is_read    = 1'b0;
      is_illegal = 1'b0;
      sel_we     = 1'b0;
      wr_en      = 1'b0;
      rd_sel     = '0;
      wr_idx     = '0;
      wr_val     = bus.cmd_data;
      case (op)
         OP_NOP:      ;
         OP_READA:    begin is_read = 1'b1; rd_sel = sel_a_q; end
         OP_READB:    begin is_read = 1'b1; rd_sel = sel_b_q; end
         OP_READSP:   begin is_read = 1'b1; rd_sel = SP_I;    end
         OP_READF:    begin is_read = 1'b1; rd_sel = F_I;     end
         OP_READRV:   begin is_read = 1'b1; rd_sel = RV_I;    end
         OP_LATCHSEL: sel_we = 1'b1;
         OP_LATCHC:   begin wr_en = 1'b1; wr_idx = sel_c_q; end
         OP_LATCHSP:  begin wr_en = 1'b1; wr_idx = SP_I;    end
         OP_LATCHF:   begin wr_en = 1'b1; wr_idx = F_I;     end
         OP_LATCHRV:  begin wr_en = 1'b1; wr_idx = RV_I;    end
         OP_INCSP:    begin wr_en = 1'b1; wr_idx = SP_I; wr_val = regs_q[SP_I] + SP_STEP_W; end
         OP_DECSP:    begin wr_en = 1'b1; wr_idx = SP_I; wr_val = regs_q[SP_I] - SP_STEP_W; end
         default:     is_illegal = 1'b1;
      endcase
   end

   // Out-of-range selects and (optionally) R0 read as zero.
   assign rd_val = ({1'b0, rd_sel} < REG_CNT && !(ZERO_R0 && rd_sel == '0)) ? regs_q[rd_sel] : '0;

   always_comb begin
      regs_d = regs_q;
      if (alu_f_we) regs_d[F_I] = alu_f_data;
      // Command writes land after the ALU write so they win on the same edge.
      for (int i = 0; i < REGISTERS; i++) begin
         if (accept && wr_en && wr_idx == i[INDEX_WIDTH-1:0] && !(ZERO_R0 && i == 0)) begin
            regs_d[i] = wr_val;
         end
      end
   end

   always_comb begin
      sel_a_d    = sel_a_q;
      sel_b_d    = sel_b_q;
      sel_c_d    = sel_c_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      err_d      = accept & is_illegal;
      if (accept && sel_we) begin
         sel_a_d = bus.cmd_data[INDEX_WIDTH-1:0];
         sel_b_d = bus.cmd_data[2*INDEX_WIDTH-1:INDEX_WIDTH];
         sel_c_d = bus.cmd_data[3*INDEX_WIDTH-1:2*INDEX_WIDTH];
      end
      if (accept && is_read) begin
         rd_valid_d = 1'b1;
         rd_data_d  = rd_val;
      end else if (bus.rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REGISTERS; i++) regs_q[i] <= '0;
         regs_q[SP_I] <= SP_RESET;
         sel_a_q      <= '0;
         sel_b_q      <= '0;
         sel_c_q      <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         sel_c_q    <= sel_c_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign f_out        = regs_q[F_I];
   assign sp_out       = regs_q[SP_I];
   assign err          = err_q;

endmodule

// File: tb/tb_cmd_regfile.sv
// Randomised and directed bench for cmd_regfile; drives a default build and a ZERO_R0=1 build in lockstep.
module tb_cmd_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_we;
   logic [15:0] alu_fd;

   cmd_regfile_if #(.DATA_WIDTH(16)) bus0 ();
   cmd_regfile_if #(.DATA_WIDTH(16)) bus1 ();

   logic [15:0] f0, sp0, f1, sp1;
   logic        err0, err1;

   cmd_regfile #(.ZERO_R0(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .alu_f_we(alu_we), .alu_f_data(alu_fd),
      .f_out(f0), .sp_out(sp0), .err(err0)
   );
   cmd_regfile #(.ZERO_R0(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .alu_f_we(alu_we), .alu_f_data(alu_fd),
      .f_out(f1), .sp_out(sp1), .err(err1)
   );

   always #5 clk = ~clk;

   logic        obs_rdy [2];
   logic        obs_v   [2];
   logic [15:0] obs_rd  [2];
   logic [15:0] obs_f   [2];
   logic [15:0] obs_sp  [2];
   logic        obs_err [2];

   assign obs_rdy[0] = bus0.cmd_ready;  assign obs_rdy[1] = bus1.cmd_ready;
   assign obs_v[0]   = bus0.rd_valid;   assign obs_v[1]   = bus1.rd_valid;
   assign obs_rd[0]  = bus0.rd_data;    assign obs_rd[1]  = bus1.rd_data;
   assign obs_f[0]   = f0;              assign obs_f[1]   = f1;
   assign obs_sp[0]  = sp0;             assign obs_sp[1]  = sp1;
   assign obs_err[0] = err0;            assign obs_err[1] = err1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: architectural registers as plain integers.
   int m_regs [2][8];
   int m_sa [2], m_sb [2], m_sc [2];
   bit m_v [2];
   int m_rdat [2];
   bit m_err [2];

   function automatic int m_read(input int d, input int idx);
      if (idx >= 8) return 0;
      if (d == 1 && idx == 0) return 0;
      return m_regs[d][idx];
   endfunction

   task automatic m_write(input int d, input int idx, input int val);
      if (idx < 8 && !(d == 1 && idx == 0)) m_regs[d][idx] = val % 65536;
   endtask

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 8; r++) m_regs[d][r] = 0;
         m_regs[d][7] = 16'hFFFE;
         m_sa[d] = 0; m_sb[d] = 0; m_sc[d] = 0;
         m_v[d] = 1'b0; m_rdat[d] = 0; m_err[d] = 1'b0;
      end
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input logic [15:0] data,
                        input bit rr, input bit fwe, input logic [15:0] fd);
      bus0.cmd_valid = v;  bus0.cmd_op = op;  bus0.cmd_data = data;  bus0.rd_ready = rr;
      bus1.cmd_valid = v;  bus1.cmd_op = op;  bus1.cmd_data = data;  bus1.rd_ready = rr;
      alu_we = fwe;
      alu_fd = fd;
   endtask

   task automatic cycle(input bit v, input logic [3:0] op, input logic [15:0] data,
                        input bit rr, input bit fwe, input logic [15:0] fd);
      bit acc, rd_new;
      bit exp_rdy;
      int rv, dat;
      @(negedge clk);
      drive(v, op, data, rr, fwe, fd);
      #1;
      dat = int'(data);
      for (int d = 0; d < 2; d++) begin
         exp_rdy = !m_v[d] || rr;
         chk($sformatf("cmd_ready[%0d]", d), obs_rdy[d], exp_rdy);
         acc    = v && exp_rdy;
         rd_new = 1'b0;
         rv     = 0;
         m_err[d] = 1'b0;
         if (acc) begin
            case (op)
               4'h1: begin rd_new = 1'b1; rv = m_read(d, m_sa[d]); end
               4'h2: begin rd_new = 1'b1; rv = m_read(d, m_sb[d]); end
               4'h5: begin rd_new = 1'b1; rv = m_read(d, 7); end
               4'h6: begin rd_new = 1'b1; rv = m_read(d, 6); end
               4'h7: begin rd_new = 1'b1; rv = m_read(d, 5); end
               default: ;
            endcase
         end
         if (fwe) m_regs[d][6] = int'(fd);
         if (acc) begin
            case (op)
               4'h3: m_write(d, m_sc[d], dat);
               4'h4: begin m_sa[d] = dat % 8; m_sb[d] = (dat / 8) % 8; m_sc[d] = (dat / 64) % 8; end
               4'h8: m_write(d, 7, dat);
               4'h9: m_write(d, 6, dat);
               4'hA: m_write(d, 5, dat);
               4'hB: m_write(d, 7, m_regs[d][7] + 2);
               4'hC: m_write(d, 7, m_regs[d][7] + 65536 - 2);
               4'hD, 4'hE, 4'hF: m_err[d] = 1'b1;
               default: ;
            endcase
         end
         if (rd_new) begin
            m_v[d] = 1'b1;
            m_rdat[d] = rv;
         end else if (rr) begin
            m_v[d] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rd_valid[%0d]", d), obs_v[d], m_v[d]);
         if (m_v[d]) chk($sformatf("rd_data[%0d]", d), obs_rd[d], m_rdat[d]);
         chk($sformatf("f_out[%0d]", d), obs_f[d], m_regs[d][6]);
         chk($sformatf("sp_out[%0d]", d), obs_sp[d], m_regs[d][7]);
         chk($sformatf("err[%0d]", d), obs_err[d], m_err[d]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 16'h0);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_rd_valid[%0d]", d), obs_v[d], 1'b0);
         chk($sformatf("rst_rd_data[%0d]", d), obs_rd[d], 16'h0);
         chk($sformatf("rst_sp[%0d]", d), obs_sp[d], 16'hFFFE);
         chk($sformatf("rst_f[%0d]", d), obs_f[d], 16'h0);
         chk($sformatf("rst_err[%0d]", d), obs_err[d], 1'b0);
      end
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 16'h0);
      m_reset();
      #12;
      do_reset();

      // Backpressure on a held result, then drain with a queued read.
      cycle(1, 4'h5, 16'h0, 0, 0, 16'h0);
      chk("t3_sp_held", obs_rd[0], 16'hFFFE);
      cycle(1, 4'h6, 16'h0, 0, 0, 16'h0);
      chk("t3_rdy_low", obs_rdy[0], 1'b0);
      chk("t3_still_sp", obs_rd[0], 16'hFFFE);
      cycle(1, 4'h6, 16'h0, 1, 0, 16'h0);
      chk("t3_readf_v", obs_v[0], 1'b1);
      chk("t3_readf", obs_rd[0], 16'h0000);
      cycle(0, 4'h0, 16'h0, 1, 0, 16'h0);

      // Select latching and write-then-read through selC/selA.
      cycle(1, 4'h4, 16'h00A1, 1, 0, 16'h0);
      cycle(1, 4'h3, 16'h1234, 1, 0, 16'h0);
      cycle(1, 4'h4, 16'h0002, 1, 0, 16'h0);
      cycle(1, 4'h1, 16'h0, 1, 0, 16'h0);
      chk("t2_reada", obs_rd[0], 16'h1234);
      cycle(1, 4'h2, 16'h0, 1, 0, 16'h0);
      chk("t2_readb", obs_rd[0], 16'h0000);

      // SP wrap in both directions.
      cycle(1, 4'h8, 16'h0000, 1, 0, 16'h0);
      cycle(1, 4'hC, 16'h0, 1, 0, 16'h0);
      chk("t4_dec_wrap", obs_sp[0], 16'hFFFE);
      cycle(1, 4'hB, 16'h0, 1, 0, 16'h0);
      cycle(1, 4'hB, 16'h0, 1, 0, 16'h0);
      chk("t4_inc_wrap", obs_sp[0], 16'h0002);

      // Flag write conflict: command beats ALU on the same edge.
      cycle(1, 4'h9, 16'h8000, 1, 1, 16'h00FF);
      chk("t5_latchf_wins", obs_f[0], 16'h8000);
      cycle(0, 4'h0, 16'h0, 1, 1, 16'h0001);
      chk("t5_alu_only", obs_f[0], 16'h0001);

      // Illegal opcode and hard-zero R0.
      cycle(1, 4'hE, 16'hBEEF, 1, 0, 16'h0);
      chk("t6_err_pulse", obs_err[0], 1'b1);
      cycle(1, 4'h0, 16'h0, 1, 0, 16'h0);
      chk("t6_err_clear", obs_err[0], 1'b0);
      chk("t6_sp_kept", obs_sp[0], 16'h0002);
      cycle(1, 4'h4, 16'h0000, 1, 0, 16'h0);
      cycle(1, 4'h3, 16'h0055, 1, 0, 16'h0);
      cycle(1, 4'h1, 16'h0, 1, 0, 16'h0);
      chk("t6_r0_normal", obs_rd[0], 16'h0055);
      chk("t6_r0_zero", obs_rd[1], 16'h0000);

      // Reset with a result pending.
      cycle(1, 4'h1, 16'h0, 0, 0, 16'h0);
      chk("t1_pending", obs_v[0], 1'b1);
      do_reset();
      cycle(1, 4'h1, 16'h0, 1, 0, 16'h0);
      chk("t1_reada_after", obs_rd[0], 16'h0000);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
